// File: rtl/fc_result_streamer.sv
// fc_result_streamer: once a fully connected layer has finished writing its
// output scratch RAM, sweep the RAM read port over addresses 0..NUM_ITEMS-1
// and present the results as an in-order valid/ready stream with index and
// last markers. Reads are only issued when the prefetch FIFO has room for
// every read still in flight, so backpressure never loses or drops data.
// Optional build macro ARGMAX_EN adds a running signed argmax (max_data and
// max_index) over the streamed items.
`timescale 1ns/1ps
module fc_result_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ITEMS  = 84,
    parameter int ADDR_WIDTH = 7,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    output logic                         rd_en,
    output logic [ADDR_WIDTH-1:0]        rd_addr,
    input  logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0]        out_index,
    output logic                         out_last,
    output logic                         done
`ifdef ARGMAX_EN
    ,
    output logic signed [DATA_WIDTH-1:0] max_data,
    output logic [ADDR_WIDTH-1:0]        max_index
`endif
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ITEMS - 1);
    localparam logic [CW-1:0]         DEPTH_C   = CW'(FIFO_DEPTH);

    logic [1:0]                   state_q, state_d;
    logic [ADDR_WIDTH-1:0]        rd_addr_q, rd_addr_d;
    logic [RD_LATENCY-1:0]        pipe_vld_q, pipe_vld_d;
    logic [ADDR_WIDTH-1:0]        pipe_idx_q [RD_LATENCY];
    logic [ADDR_WIDTH-1:0]        pipe_idx_d [RD_LATENCY];
    logic signed [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic signed [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]        fifo_idx_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]        fifo_idx_d [FIFO_DEPTH];
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]                count_q, count_d;
    logic [CW-1:0]                in_flight;
    logic                         issue, push, pop;

    // Credit check: a read may only go out if its data is guaranteed a FIFO slot.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + CW'(pipe_vld_q[i]);
        end
    end

    assign issue     = en && (state_q == S_READ) && ((count_q + in_flight) < DEPTH_C);
    assign rd_en     = issue;
    assign rd_addr   = rd_addr_q;
    assign push      = pipe_vld_q[RD_LATENCY-1];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_index = out_valid ? fifo_idx_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && (out_index == LAST_ADDR);
    assign done      = (state_q == S_DONE);

    // Valid/index tag pipeline matching the RAM read latency; dropping en kills it.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                assign pipe_vld_d[gi] = issue;
                assign pipe_idx_d[gi] = rd_addr_q;
            end else begin : g_next
                assign pipe_vld_d[gi] = en && pipe_vld_q[gi-1];
                assign pipe_idx_d[gi] = pipe_idx_q[gi-1];
            end
        end
    endgenerate

    // Sweep sequencing and read address generation.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        if (issue) begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
        case (state_q)
            S_IDLE: begin
                rd_addr_d = '0;
                if (en) state_d = S_READ;
            end
            S_READ:  if (issue && (rd_addr_q == LAST_ADDR)) state_d = S_DRAIN;
            S_DRAIN: if (pop && out_last) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (!en) begin
            state_d   = S_IDLE;
            rd_addr_d = '0;
        end
    end

    // Prefetch FIFO: push returned data with its tag, pop on handshake, flush on abort.
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_idx_d  = fifo_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = rd_data;
            fifo_idx_d[wr_ptr_q]  = pipe_idx_q[RD_LATENCY-1];
            wr_ptr_d              = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
        if (!en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            pipe_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pipe_idx_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            pipe_vld_q <= pipe_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int i = 0; i < RD_LATENCY; i++) pipe_idx_q[i] <= pipe_idx_d[i];
        end
    end

    // FIFO storage carries no reset; outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        fifo_data_q <= fifo_data_d;
        fifo_idx_q  <= fifo_idx_d;
    end

`ifdef ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] max_data_q, max_data_d;
    logic [ADDR_WIDTH-1:0]        max_index_q, max_index_d;
    logic                         max_seen_q, max_seen_d;

    // Running argmax: first item loads, strictly greater replaces, ties keep the earlier index.
    always_comb begin
        max_data_d  = max_data_q;
        max_index_d = max_index_q;
        max_seen_d  = max_seen_q;
        if ((state_q == S_IDLE) && en) begin
            max_data_d  = '0;
            max_index_d = '0;
            max_seen_d  = 1'b0;
        end else if (pop && (!max_seen_q || (out_data > max_data_q))) begin
            max_data_d  = out_data;
            max_index_d = out_index;
            max_seen_d  = 1'b1;
        end
    end

    // Argmax registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_data_q  <= '0;
            max_index_q <= '0;
            max_seen_q  <= 1'b0;
        end else begin
            max_data_q  <= max_data_d;
            max_index_q <= max_index_d;
            max_seen_q  <= max_seen_d;
        end
    end

    assign max_data  = max_data_q;
    assign max_index = max_index_q;
`endif

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count_q == DEPTH_C)));
`endif
endmodule

// File: tb/tb_fc_result_streamer.sv
// Bench for fc_result_streamer: two instances (read latency 1 and 3) share
// the stimulus. A startup vector table pins cycle-exact behaviour; a
// scoreboard expects every sweep to deliver items 0..83 in order with the
// RAM contents, and tracks outstanding reads to police the credit rule.
`timescale 1ns/1ps
module tb_fc_result_streamer;
    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int N     = 84;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic out_ready = 1'b0;
    always #5 clk = ~clk;

    logic                 rd_en1, rd_en3, ov1, ov3, ol1, ol3, done1, done3;
    logic [AW-1:0]        rd_addr1, rd_addr3, oi1, oi3;
    logic signed [DW-1:0] rd_data1, rd_data3, od1, od3, p3a, p3b;
`ifdef ARGMAX_EN
    logic signed [DW-1:0] mx1, mx3;
    logic [AW-1:0]        mi1, mi3;
`endif

    logic signed [DW-1:0] ram [128];

    // RAM models: latency 1 and latency 3, garbage when not strobed.
    always @(posedge clk) begin
        rd_data1 <= rd_en1 ? ram[rd_addr1] : 16'sh7bad;
        p3a      <= rd_en3 ? ram[rd_addr3] : 16'sh7bad;
        p3b      <= p3a;
        rd_data3 <= p3b;
    end

    fc_result_streamer #(.DATA_WIDTH(DW), .NUM_ITEMS(N), .ADDR_WIDTH(AW),
                         .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .rst(rst), .en(en), .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .out_valid(ov1), .out_ready(out_ready),
        .out_data(od1), .out_index(oi1), .out_last(ol1), .done(done1)
`ifdef ARGMAX_EN
        , .max_data(mx1), .max_index(mi1)
`endif
    );

    fc_result_streamer #(.DATA_WIDTH(DW), .NUM_ITEMS(N), .ADDR_WIDTH(AW),
                         .RD_LATENCY(3), .FIFO_DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst(rst), .en(en), .rd_en(rd_en3), .rd_addr(rd_addr3),
        .rd_data(rd_data3), .out_valid(ov3), .out_ready(out_ready),
        .out_data(od3), .out_index(oi3), .out_last(ol3), .done(done3)
`ifdef ARGMAX_EN
        , .max_data(mx3), .max_index(mi3)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string name, input logic signed [31:0] act,
                            input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard state, one slot per instance.
    int                   exp_idx [2];
    int                   exp_issue [2];
    int                   outst [2];
    bit                   stall_prev [2];
    bit                   last_prev [2];
    bit                   done_prev [2];
    logic signed [DW-1:0] data_prev [2];
    logic [AW-1:0]        idx_prev [2];
    bit                   mon_on = 1'b0;

    task automatic mon_step(input int w, input logic re, input logic [AW-1:0] ra,
                            input logic ov, input logic signed [DW-1:0] od,
                            input logic [AW-1:0] oi, input logic ol, input logic dn);
        string tag;
        bit hs;
        bit hs_last;
        tag     = (w == 0) ? "L1" : "L3";
        hs      = (ov === 1'b1) && (out_ready === 1'b1);
        hs_last = 1'b0;
        if (stall_prev[w]) begin
            check_eq({tag, "_stall_valid"}, ov, 1);
            check_eq({tag, "_stall_data"}, od, data_prev[w]);
            check_eq({tag, "_stall_index"}, oi, idx_prev[w]);
        end
        if (last_prev[w]) check_eq({tag, "_done_after_last"}, dn, 1);
        if ((dn === 1'b1) && !done_prev[w]) check_eq({tag, "_done_item_count"}, exp_idx[w], N);
        if (ov !== 1'b1) check_eq({tag, "_last_while_idle"}, ol, 0);
        if (re === 1'b1) begin
            check_eq({tag, "_credit"}, outst[w] < DEPTH, 1);
            check_eq({tag, "_rd_addr_order"}, ra, exp_issue[w]);
            exp_issue[w]++;
            outst[w]++;
        end
        if (hs) begin
            if (exp_idx[w] < N) begin
                check_eq({tag, "_item_index"}, oi, exp_idx[w]);
                check_eq({tag, "_item_data"}, od, ram[exp_idx[w]]);
                check_eq({tag, "_item_last"}, ol, (exp_idx[w] == N - 1) ? 1 : 0);
                hs_last = (exp_idx[w] == N - 1);
            end else begin
                check_eq({tag, "_extra_item"}, exp_idx[w], N - 1);
            end
            exp_idx[w]++;
            outst[w]--;
        end
        stall_prev[w] = (ov === 1'b1) && (out_ready !== 1'b1);
        data_prev[w]  = od;
        idx_prev[w]   = oi;
        last_prev[w]  = hs_last;
        done_prev[w]  = (dn === 1'b1);
        if ((rst === 1'b1) || (en !== 1'b1)) begin
            exp_idx[w]    = 0;
            exp_issue[w]  = 0;
            outst[w]      = 0;
            stall_prev[w] = 1'b0;
            last_prev[w]  = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_step(0, rd_en1, rd_addr1, ov1, od1, oi1, ol1, done1);
            mon_step(1, rd_en3, rd_addr3, ov3, od3, oi3, ol3, done3);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_L1_rd_en"}, rd_en1, 0);
        check_eq({tag, "_L1_rd_addr"}, rd_addr1, 0);
        check_eq({tag, "_L1_out_valid"}, ov1, 0);
        check_eq({tag, "_L1_out_last"}, ol1, 0);
        check_eq({tag, "_L1_done"}, done1, 0);
        check_eq({tag, "_L3_rd_en"}, rd_en3, 0);
        check_eq({tag, "_L3_rd_addr"}, rd_addr3, 0);
        check_eq({tag, "_L3_out_valid"}, ov3, 0);
        check_eq({tag, "_L3_out_last"}, ol3, 0);
        check_eq({tag, "_L3_done"}, done3, 0);
    endtask

    task automatic check_zero_data(input string tag);
        check_eq({tag, "_L1_out_data"}, od1, 0);
        check_eq({tag, "_L1_out_index"}, oi1, 0);
        check_eq({tag, "_L3_out_data"}, od3, 0);
        check_eq({tag, "_L3_out_index"}, oi3, 0);
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready.
    // target < 0 waits for both done, otherwise for latency-1 handshake count.
    task automatic run_until(input int mode, input int target);
        bit reached;
        reached = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            if (target < 0) reached = (done1 === 1'b1) && (done3 === 1'b1);
            else            reached = (exp_idx[0] >= target);
            if (reached) break;
            en = 1'b1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((c % 4) == 0) || ((c % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
        check_eq($sformatf("sweep_reached_mode%0d_target%0d", mode, target), reached, 1);
    endtask

    task automatic end_sweep();
        en = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_eq("done_same_cycle_en_low_L1", done1, 1);
        check_eq("done_same_cycle_en_low_L3", done3, 1);
        next_cycle();
        @(negedge clk);
        check_idle("after_sweep");
    endtask

    typedef struct {
        int en, rdy, re1, ra1, ov1, oi1, re3, ra3, ov3, oi3;
    } vec_t;
    vec_t vecs [7];

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int exp_max;
        int exp_arg;
        // en, rdy | L1: rd_en, rd_addr, valid, index | L3: rd_en, rd_addr, valid, index
        vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0};
        vecs[2] = '{1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
        vecs[3] = '{1, 1, 1, 2, 1, 0, 1, 2, 0, 0};
        vecs[4] = '{1, 1, 1, 3, 1, 1, 1, 3, 0, 0};
        vecs[5] = '{1, 1, 1, 4, 1, 2, 0, 4, 1, 0};
        vecs[6] = '{1, 1, 1, 5, 1, 3, 1, 4, 1, 1};

        for (int i = 0; i < 128; i++) ram[i] = 16'(i - 42);

        repeat (3) next_cycle();
        @(negedge clk);
        check_idle("reset");
        check_zero_data("reset");
        next_cycle();
        rst = 1'b0;
        mon_on = 1'b1;

        // Basic sweep, cycle-exact startup for both latencies.
        for (int k = 0; k < 7; k++) begin
            next_cycle();
            en = vecs[k].en[0];
            out_ready = vecs[k].rdy[0];
            @(negedge clk);
            check_eq($sformatf("vec%0d_L1_rd_en", k), rd_en1, vecs[k].re1);
            check_eq($sformatf("vec%0d_L1_rd_addr", k), rd_addr1, vecs[k].ra1);
            check_eq($sformatf("vec%0d_L1_out_valid", k), ov1, vecs[k].ov1);
            if (vecs[k].ov1 != 0) check_eq($sformatf("vec%0d_L1_out_index", k), oi1, vecs[k].oi1);
            check_eq($sformatf("vec%0d_L3_rd_en", k), rd_en3, vecs[k].re3);
            check_eq($sformatf("vec%0d_L3_rd_addr", k), rd_addr3, vecs[k].ra3);
            check_eq($sformatf("vec%0d_L3_out_valid", k), ov3, vecs[k].ov3);
            if (vecs[k].ov3 != 0) check_eq($sformatf("vec%0d_L3_out_index", k), oi3, vecs[k].oi3);
        end
        run_until(0, -1);
        end_sweep();

        // Backpressure 1,0,0,1 on random data.
        for (int i = 0; i < 128; i++) ram[i] = 16'($urandom);
        run_until(1, -1);
        end_sweep();

        // Random backpressure on random data.
        for (int i = 0; i < 128; i++) ram[i] = 16'($urandom);
        run_until(2, -1);
        end_sweep();

        // Abort after 20 handshakes, then a fresh sweep.
        run_until(0, 20);
        en = 1'b0;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check_idle("abort");
        run_until(0, -1);
        end_sweep();

        // Synchronous reset mid-sweep with en held high.
        run_until(2, 50);
        rst = 1'b1;
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        check_zero_data("mid_reset");
        run_until(0, -1);
        end_sweep();

`ifdef ARGMAX_EN
        for (int i = 0; i < 128; i++) ram[i] = -16'sd5;
        ram[17] = 16'sd300;
        ram[60] = 16'sd300;
        run_until(1, -1);
        check_eq("argmax_L1_data", mx1, 300);
        check_eq("argmax_L1_index", mi1, 17);
        check_eq("argmax_L3_data", mx3, 300);
        check_eq("argmax_L3_index", mi3, 17);
        end_sweep();

        for (int i = 0; i < 128; i++) ram[i] = 16'(-int'($urandom_range(1, 1000)));
        exp_max = int'(ram[0]);
        exp_arg = 0;
        for (int i = 1; i < N; i++) begin
            if (int'(ram[i]) > exp_max) begin
                exp_max = int'(ram[i]);
                exp_arg = i;
            end
        end
        run_until(2, -1);
        check_eq("argmax_neg_L1_data", mx1, exp_max);
        check_eq("argmax_neg_L1_index", mi1, exp_arg);
        check_eq("argmax_neg_L3_data", mx3, exp_max);
        check_eq("argmax_neg_L3_index", mi3, exp_arg);
        end_sweep();
`else
        exp_max = 0;
        exp_arg = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
